// File: rtl/lpc_tpm_frontend.sv
// LPC target front end for TPM-locality cycles: turns LFRAME#/LAD nibble traffic into
// single-byte register accesses toward the TIS peripheral and answers with SYNC/read data.
module lpc_tpm_frontend #(
  parameter logic [3:0]  START_CODE = 4'b0101,
  parameter int unsigned SYNC_WAIT  = 0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        lframeN,
  input  logic [3:0]  ladIn,
  output logic [3:0]  ladOut,
  output logic        ladOe,
  output logic [15:0] periphAddr,
  output logic [7:0]  periphOutData,
  output logic        periphDidWrite,
  output logic        periphDidRead,
  input  logic [7:0]  periphInData,
  output logic        cycleAbort
);

  localparam logic [3:0] SyncWaitInit = 4'(SYNC_WAIT);
  localparam logic [3:0] CycRead      = 4'b0000;
  localparam logic [3:0] CycWrite     = 4'b0010;
  localparam logic [3:0] SyncLong     = 4'b0110;
  localparam logic [3:0] SyncReady    = 4'b0000;

  typedef enum logic [3:0] {
    StIdle,
    StCycType,
    StAddr,
    StWData,
    StTarH,
    StSync,
    StRData,
    StTarP,
    StIgnore
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [1:0]  nibCnt;
  logic        isWrite;
  logic [11:0] addrShift;
  logic [3:0]  wdataLo;
  logic [7:0]  rdataLatch;
  logic [3:0]  waitCnt;
  logic        lframePrevN;
  logic        startHit;

  assign startHit = !lframeN && (ladIn == START_CODE);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; any LFRAME# assertion restarts decoding from T0
  always_comb begin
    stateNext = state;
    if (!lframeN) begin
      stateNext = startHit ? StCycType : StIgnore;
    end else begin
      unique case (state)
        StCycType: begin
          if (ladIn == CycRead || ladIn == CycWrite) stateNext = StAddr;
          else                                       stateNext = StIgnore;
        end
        StAddr:  if (nibCnt == 2'd3) stateNext = isWrite ? StWData : StTarH;
        StWData: if (nibCnt == 2'd1) stateNext = StTarH;
        StTarH:  if (nibCnt == 2'd1) stateNext = StSync;
        StSync:  if (waitCnt == 4'd0) stateNext = isWrite ? StTarP : StRData;
        StRData: if (nibCnt == 2'd1) stateNext = StTarP;
        StTarP:  if (nibCnt == 2'd1) stateNext = StIdle;
        default: stateNext = state;
      endcase
    end
  end

  // Datapath: nibble counter, address/data capture, SYNC wait counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      nibCnt        <= 2'd0;
      isWrite       <= 1'b0;
      addrShift     <= 12'd0;
      periphAddr    <= 16'd0;
      wdataLo       <= 4'd0;
      periphOutData <= 8'd0;
      rdataLatch    <= 8'd0;
      waitCnt       <= 4'd0;
      lframePrevN   <= 1'b1;
    end else begin
      lframePrevN <= lframeN;
      nibCnt      <= (stateNext != state) ? 2'd0 : nibCnt + 2'd1;

      if (startHit) begin
        waitCnt <= SyncWaitInit;
      end else if (lframeN && state == StSync && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (lframeN) begin
        unique case (state)
          StCycType: isWrite <= (ladIn == CycWrite);
          StAddr: begin
            addrShift <= {addrShift[7:0], ladIn};
            // Publish the address only once all four nibbles have arrived
            if (nibCnt == 2'd3) periphAddr <= {addrShift, ladIn};
          end
          StWData: begin
            if (nibCnt == 2'd0) wdataLo       <= ladIn;
            else                periphOutData <= {ladIn, wdataLo};
          end
          StSync: begin
            // Downstream may pop its FIFO on the strobe, so hold our own copy
            if (!isWrite && waitCnt == 4'd0) rdataLatch <= periphInData;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs; LAD drive is cut combinationally by LFRAME# so an abort releases the bus at once
  always_comb begin
    ladOe          = 1'b0;
    ladOut         = 4'hF;
    periphDidWrite = 1'b0;
    periphDidRead  = 1'b0;
    cycleAbort     = 1'b0;
    if (lframeN) begin
      unique case (state)
        StTarH: periphDidWrite = isWrite && (nibCnt == 2'd0);
        StSync: begin
          ladOe         = 1'b1;
          ladOut        = (waitCnt != 4'd0) ? SyncLong : SyncReady;
          periphDidRead = !isWrite && (waitCnt == 4'd0);
        end
        StRData: begin
          ladOe  = 1'b1;
          ladOut = nibCnt[0] ? rdataLatch[7:4] : rdataLatch[3:0];
        end
        StTarP: begin
          ladOe  = (nibCnt == 2'd0);
          ladOut = 4'hF;
        end
        default: ;
      endcase
    end else begin
      // Only the first low LFRAME# cycle of a claimed transfer counts as the abort
      cycleAbort = lframePrevN && (state != StIdle) && (state != StIgnore);
    end
  end

endmodule

// File: tb/tb_lpc_tpm_frontend.sv
// Directed bench for lpc_tpm_frontend: one instance with no SYNC wait, one with three.
module tb_lpc_tpm_frontend;

  logic        clk;
  logic        resetN;
  logic        lframeN;
  logic [3:0]  ladIn;
  logic [7:0]  periphInData;

  logic [3:0]  ladOut0, ladOut3;
  logic        ladOe0, ladOe3;
  logic [15:0] addr0, addr3;
  logic [7:0]  outData0, outData3;
  logic        wr0, wr3, rd0, rd3, abort0, abort3;

  int checks = 0;
  int errors = 0;
  int wrCnt0 = 0, rdCnt0 = 0, abortCnt0 = 0;
  int wrCnt3 = 0, rdCnt3 = 0;

  lpc_tpm_frontend #(.START_CODE(4'b0101), .SYNC_WAIT(0)) dut0 (
    .clk            (clk),
    .resetN         (resetN),
    .lframeN        (lframeN),
    .ladIn          (ladIn),
    .ladOut         (ladOut0),
    .ladOe          (ladOe0),
    .periphAddr     (addr0),
    .periphOutData  (outData0),
    .periphDidWrite (wr0),
    .periphDidRead  (rd0),
    .periphInData   (periphInData),
    .cycleAbort     (abort0)
  );

  lpc_tpm_frontend #(.START_CODE(4'b0101), .SYNC_WAIT(3)) dut3 (
    .clk            (clk),
    .resetN         (resetN),
    .lframeN        (lframeN),
    .ladIn          (ladIn),
    .ladOut         (ladOut3),
    .ladOe          (ladOe3),
    .periphAddr     (addr3),
    .periphOutData  (outData3),
    .periphDidWrite (wr3),
    .periphDidRead  (rd3),
    .periphInData   (periphInData),
    .cycleAbort     (abort3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr0)    wrCnt0    <= wrCnt0 + 1;
    if (rd0)    rdCnt0    <= rdCnt0 + 1;
    if (abort0) abortCnt0 <= abortCnt0 + 1;
    if (wr3)    wrCnt3    <= wrCnt3 + 1;
    if (rd3)    rdCnt3    <= rdCnt3 + 1;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One LPC clock: drive on the falling edge, sample 1 ns later
  task automatic step(input logic lf, input logic [3:0] lad);
    @(negedge clk);
    lframeN = lf;
    ladIn   = lad;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'hF);
  endtask

  // T0..T5: START, CYCTYPE, four address nibbles MSN first
  task automatic sendHeader(input logic wr, input logic [15:0] addr);
    step(1'b0, 4'b0101);
    step(1'b1, wr ? 4'h2 : 4'h0);
    step(1'b1, addr[15:12]);
    step(1'b1, addr[11:8]);
    step(1'b1, addr[7:4]);
    step(1'b1, addr[3:0]);
  endtask

  int  base, base2;
  logic oeSeen;

  initial begin
    resetN       = 1'b0;
    lframeN      = 1'b1;
    ladIn        = 4'hF;
    periphInData = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst ladOe", ladOe0, 1'b0);
    checkVal("rst ladOut", ladOut0, 4'hF);
    checkVal("rst addr", addr0, 16'h0000);
    checkVal("rst outData", outData0, 8'h00);
    checkVal("rst strobes", {wr0, rd0, abort0}, 3'b000);
    checkVal("rst ladOe3", ladOe3, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    idle(2);

    // Write 0x02 to 0x0000
    base = wrCnt0;
    sendHeader(1'b1, 16'h0000);
    step(1'b1, 4'h2);                                  // T6
    checkVal("wr T6 no strobe", wr0, 1'b0);
    step(1'b1, 4'h0);                                  // T7
    checkVal("wr T7 no strobe", wr0, 1'b0);
    step(1'b1, 4'hF);                                  // T8
    checkVal("wr T8 strobe", wr0, 1'b1);
    checkVal("wr T8 addr", addr0, 16'h0000);
    checkVal("wr T8 data", outData0, 8'h02);
    checkVal("wr T8 ladOe", ladOe0, 1'b0);
    step(1'b1, 4'hF);                                  // T9
    checkVal("wr T9 no strobe", wr0, 1'b0);
    step(1'b1, 4'hF);                                  // T10
    checkVal("wr T10 sync", {ladOe0, ladOut0}, 5'h10);
    step(1'b1, 4'hF);                                  // T11
    checkVal("wr T11 tar", {ladOe0, ladOut0}, 5'h1F);
    step(1'b1, 4'hF);                                  // T12
    checkVal("wr T12 release", {ladOe0, ladOut0}, 5'h0F);
    idle(6);
    checkVal("wr strobe count", wrCnt0 - base, 1);

    // Read 0x0018 returning 0x84
    periphInData = 8'h84;
    sendHeader(1'b0, 16'h0018);
    step(1'b1, 4'hF);                                  // T6
    checkVal("rd addr", addr0, 16'h0018);
    checkVal("rd T6 ladOe", ladOe0, 1'b0);
    step(1'b1, 4'hF);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    checkVal("rd T8 strobe", rd0, 1'b1);
    checkVal("rd T8 sync", {ladOe0, ladOut0}, 5'h10);
    step(1'b1, 4'hF);                                  // T9
    checkVal("rd T9 lsn", {ladOe0, ladOut0}, 5'h14);
    checkVal("rd T9 no strobe", rd0, 1'b0);
    step(1'b1, 4'hF);                                  // T10
    checkVal("rd T10 msn", {ladOe0, ladOut0}, 5'h18);
    step(1'b1, 4'hF);                                  // T11
    checkVal("rd T11 tar", {ladOe0, ladOut0}, 5'h1F);
    step(1'b1, 4'hF);                                  // T12
    checkVal("rd T12 release", ladOe0, 1'b0);
    idle(6);

    // SYNC_WAIT=3 read of 0x0024; input byte changes after the strobe
    periphInData = 8'h11;
    sendHeader(1'b0, 16'h0024);
    step(1'b1, 4'hF);                                  // T6
    step(1'b1, 4'hF);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    checkVal("w3 T8 wait", {ladOe3, ladOut3}, 5'h16);
    step(1'b1, 4'hF);                                  // T9
    checkVal("w3 T9 wait", {ladOe3, ladOut3}, 5'h16);
    step(1'b1, 4'hF);                                  // T10
    checkVal("w3 T10 wait", {ladOe3, ladOut3}, 5'h16);
    checkVal("w3 T10 no strobe", rd3, 1'b0);
    step(1'b1, 4'hF);                                  // T11
    checkVal("w3 T11 ready", {ladOe3, ladOut3}, 5'h10);
    checkVal("w3 T11 strobe", rd3, 1'b1);
    @(negedge clk);                                    // T12
    lframeN      = 1'b1;
    ladIn        = 4'hF;
    periphInData = 8'h22;
    #1;
    checkVal("w3 T12 lsn", {ladOe3, ladOut3}, 5'h11);
    checkVal("w3 T12 no strobe", rd3, 1'b0);
    step(1'b1, 4'hF);                                  // T13
    checkVal("w3 T13 msn", {ladOe3, ladOut3}, 5'h11);
    step(1'b1, 4'hF);                                  // T14
    checkVal("w3 T14 tar", {ladOe3, ladOut3}, 5'h1F);
    step(1'b1, 4'hF);                                  // T15
    checkVal("w3 T15 release", ladOe3, 1'b0);
    idle(4);

    // Abort at T4 of a write, then an immediate write of 0x40 to 0x0018
    base  = wrCnt0;
    base2 = abortCnt0;
    step(1'b0, 4'b0101);
    step(1'b1, 4'h2);
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    step(1'b0, 4'hF);                                  // T4
    checkVal("abort pulse", abort0, 1'b1);
    checkVal("abort ladOe", ladOe0, 1'b0);
    checkVal("abort addr held", addr0, 16'h0024);
    sendHeader(1'b1, 16'h0018);
    step(1'b1, 4'h0);                                  // T6
    step(1'b1, 4'h4);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    checkVal("ab wr strobe", wr0, 1'b1);
    checkVal("ab wr addr", addr0, 16'h0018);
    checkVal("ab wr data", outData0, 8'h40);
    idle(8);
    checkVal("ab wr count", wrCnt0 - base, 1);
    checkVal("abort count", abortCnt0 - base2, 1);

    // Unsupported cycle type (memory read) is ignored
    base   = wrCnt0 + rdCnt0 + wrCnt3 + rdCnt3;
    oeSeen = 1'b0;
    step(1'b0, 4'b0101);
    step(1'b1, 4'h4);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)));
      oeSeen = oeSeen | ladOe0 | ladOe3;
    end
    checkVal("ign ladOe", oeSeen, 1'b0);
    checkVal("ign strobes", wrCnt0 + rdCnt0 + wrCnt3 + rdCnt3 - base, 0);
    periphInData = 8'h5A;
    sendHeader(1'b0, 16'h0001);
    step(1'b1, 4'hF);                                  // T6
    checkVal("ign next addr", addr0, 16'h0001);
    step(1'b1, 4'hF);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    checkVal("ign next strobe", rd0, 1'b1);
    step(1'b1, 4'hF);                                  // T9
    checkVal("ign next lsn", {ladOe0, ladOut0}, 5'h1A);
    step(1'b1, 4'hF);                                  // T10
    checkVal("ign next msn", {ladOe0, ladOut0}, 5'h15);
    idle(8);

    // Reset during the second SYNC wait nibble of a SYNC_WAIT=3 read
    base = rdCnt3;
    sendHeader(1'b0, 16'h0030);
    step(1'b1, 4'hF);                                  // T6
    step(1'b1, 4'hF);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    step(1'b1, 4'hF);                                  // T9
    checkVal("rst mid wait", {ladOe3, ladOut3}, 5'h16);
    resetN = 1'b0;
    #1;
    checkVal("rst mid ladOe", ladOe3, 1'b0);
    checkVal("rst mid ladOut", ladOut3, 4'hF);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    idle(8);
    checkVal("rst mid no read", rdCnt3 - base, 0);
    checkVal("rst mid addr", addr3, 16'h0000);

    // Back-to-back write then read after reset
    base  = wrCnt3;
    base2 = rdCnt3;
    sendHeader(1'b1, 16'h0005);
    step(1'b1, 4'hE);                                  // T6
    step(1'b1, 4'h7);                                  // T7
    step(1'b1, 4'hF);                                  // T8
    checkVal("b2b wr strobe", wr3, 1'b1);
    checkVal("b2b wr data", outData3, 8'h7E);
    idle(7);                                           // T9..T15
    periphInData = 8'hC3;
    sendHeader(1'b0, 16'h0005);
    for (int t = 6; t <= 15; t++) begin
      step(1'b1, 4'hF);
      if (t == 11) checkVal("b2b rd strobe", rd3, 1'b1);
      if (t == 12) checkVal("b2b rd lsn", {ladOe3, ladOut3}, 5'h13);
    end
    idle(2);
    checkVal("b2b wr count", wrCnt3 - base, 1);
    checkVal("b2b rd count", rdCnt3 - base2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lpc_tpm_frontend.md
Name: lpc_tpm_frontend

Overview:
- LPC bus target for TPM-locality cycles. Decodes host LFRAME#/LAD nibble traffic into single-byte register accesses and answers with SYNC and read data.
- Sits directly upstream of the TIS peripheral state machine. Drives its periphAddr, periphOutData, periphDidWrite and periphDidRead, and consumes its combinational periphInData.
- clk is LCLK; LPC inputs arrive synchronous to it, so no resynchronisers are needed.

Parameters:
- START_CODE, 4'b0101: LAD START nibble that claims a cycle (TPM locality start).
- SYNC_WAIT, 0: number of long-wait SYNC nibbles (4'b0110) driven before the ready SYNC (4'b0000); range 0-15.

Ports:
- clk  in  1  LPC clock.
- resetN  in  1  asynchronous active-low reset.
- lframeN  in  1  LPC LFRAME#.
- ladIn  in  4  sampled LAD.
- ladOut  out  4  LAD drive value.
- ladOe  out  1  LAD output enable; 1 = block drives LAD.
- periphAddr  out  16  register address of current/last access.
- periphOutData  out  8  write byte.
- periphDidWrite  out  1  one-cycle write strobe.
- periphDidRead  out  1  one-cycle read strobe.
- periphInData  in  8  read byte, combinational from periphAddr.
- cycleAbort  out  1  one-cycle pulse when a claimed cycle is aborted.

Behaviour:
- Reset (async, resetN=0):
  - State IDLE, ladOe=0, ladOut=4'hF, periphAddr=0, periphOutData=0.
  - All strobes and cycleAbort are 0. Wait counter is 0.
- States: IDLE, CYCTYPE, ADDR(4 nibbles), WDATA(2), TAR_H(2), SYNC, RDATA(2), TAR_P(2), IGNORE.
- Cycle start:
  - T0: lframeN=0 and ladIn=START_CODE moves to CYCTYPE.
  - Consecutive lframeN=0 cycles: the last nibble seen decides.
  - lframeN=0 with any other nibble moves to IGNORE.
- CYCTYPE (T1):
  - ladIn=4'b0000 selects a read; ladIn=4'b0010 selects a write. Either goes to ADDR.
  - Any other value goes to IGNORE.
  - IGNORE leaves only on the next valid START.
- ADDR (T2-T5):
  - Address is shifted in MSN first into an internal register.
  - periphAddr updates only at the end of T5 and holds until the next completed address phase.
- Write cycle:
  - T6-T7 WDATA: LSN first, then MSN.
  - T8-T9 TAR_H: host-owned, ladOe=0. periphDidWrite=1 during T8 only, with periphOutData and periphAddr stable.
  - SYNC: SYNC_WAIT cycles of 4'b0110, then one cycle of 4'b0000, all with ladOe=1.
  - TAR_P: cycle 1 drives 4'hF with ladOe=1; cycle 2 sets ladOe=0. Then IDLE.
- Read cycle:
  - T6-T7 TAR_H, ladOe=0.
  - SYNC: wait nibbles as for writes.
  - Ready-SYNC cycle: periphInData is latched into an internal byte and periphDidRead=1 for that cycle only.
  - RDATA: drives the latched LSN, then MSN. The latched byte is used because downstream may advance its FIFO after the strobe.
  - TAR_P as for writes, then IDLE.
- Exactly one strobe per completed cycle. No strobe at all for aborted or ignored cycles.
- Abort:
  - lframeN=0 in any state other than IDLE/IGNORE ends the cycle immediately: ladOe=0 that same cycle (combinational off lframeN), cycleAbort=1 for one cycle.
  - That nibble is then evaluated as a T0 START.
  - A strobe already issued (T8 write, ready-SYNC read) is not retracted.
- ladOe is 1 only in SYNC, RDATA and the first TAR_P cycle. ladOut is 4'hF whenever ladOe=0.
- Reset mid-cycle: ladOe drops asynchronously, no strobe fires, and the next cycle needs a fresh START.
- Wait counter: 4 bits, counts down from SYNC_WAIT and is reloaded at every START.

Test Plan:
- Write 0x02 to 0x0000, SYNC_WAIT=0:
  - lframeN=0/LAD=5 at T0, then 2, 0,0,0,0, 2,0 (LSN first).
  - periphDidWrite=1 at T8 only, with periphAddr=0x0000 and periphOutData=0x02.
  - ladOut=0 with ladOe=1 at T10; ladOe=0 from T12 on.
- Read 0x0018 with periphInData=0x84, SYNC_WAIT=0:
  - periphAddr=0x0018 after T5; periphDidRead=1 at T8.
  - ladOut: 0 (T8), 4 (T9), 8 (T10), F (T11); ladOe=0 at T12.
- SYNC_WAIT=3, read of 0x0024 while the bench changes periphInData from 0x11 to 0x22 on the cycle after the strobe:
  - ladOut 6,6,6,0, then 1,1: the latched byte is returned.
- Abort at T4 of a write:
  - lframeN=0 with LAD=F gives cycleAbort=1 and no periphDidWrite.
  - An immediately following valid write of 0x40 to 0x0018 completes normally.
- Unsupported cycle: START 5 then CYCTYPE 4 (memory read):
  - No strobes and ladOe stays 0 through 15 cycles of arbitrary LAD.
  - The next valid START is accepted.
- resetN=0 during the second SYNC wait nibble:
  - ladOe=0 immediately and periphDidRead never pulses.
  - After release, a back-to-back write then read each produce exactly one strobe.
